// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial line of the UART frame transmitter.
`timescale 1ns/1ps
interface uart_tx_frame_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] DATA_IN;
  logic              START;
  logic              BUSY;
  logic              DONE;
  logic              TX;

  modport master (output DATA_IN, START, input BUSY, DONE, TX);
  modport slave  (input DATA_IN, START, output BUSY, DONE, TX);
endinterface

// File: rtl/uart_tx_frame.sv
// LSB-first async frame transmitter (start, data, [parity], stop) with its own bit-rate counter.
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0
) (
  input logic            CLK,
  input logic            RESET,
  uart_tx_frame_if.slave bus
);
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_W = DATA_W + 3;
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
`else
  localparam int FRAME_W = DATA_W + 2;
`endif
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FRAME_W);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [BW-1:0]      baud_cnt;
  logic [CW-1:0]      bit_cnt;
  logic               busy;
  logic               done;
  logic [FRAME_W-1:0] load_word;

  always_comb begin
`ifdef UART_TX_PARITY_EN
    load_word = {1'b1, (^bus.DATA_IN) ^ PAR_SENSE, bus.DATA_IN, 1'b0};
`else
    load_word = {1'b1, bus.DATA_IN, 1'b0};
`endif
  end

  // Gating by state makes TX return high the instant reset drops the FSM to IDLE.
  assign bus.TX   = (state == SHIFT) ? shreg[0] : 1'b1;
  assign bus.BUSY = busy;
  assign bus.DONE = done;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          done <= 1'b0;
          if (bus.START) begin
            shreg    <= load_word;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shreg    <= {1'b1, shreg[FRAME_W-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (even/odd parity sense) against a frame-position model.
`timescale 1ns/1ps
module tb_uart_tx_frame;
  localparam int DATA_W = 8;
  localparam int C      = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FW = DATA_W + 3;
`else
  localparam int FW = DATA_W + 2;
`endif
  localparam int FT = FW * C;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data_in = '0;

  always #5 CLK = ~CLK;

  uart_tx_frame_if #(.DATA_W(DATA_W)) b0 ();
  uart_tx_frame_if #(.DATA_W(DATA_W)) b1 ();
  assign b0.START   = start;
  assign b0.DATA_IN = data_in;
  assign b1.START   = start;
  assign b1.DATA_IN = data_in;

  uart_tx_frame #(.DATA_W(DATA_W), .CLKS_PER_BIT(C), .PARITY_ODD(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(b0));
  uart_tx_frame #(.DATA_W(DATA_W), .CLKS_PER_BIT(C), .PARITY_ODD(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(b1));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] frame_of(input logic [DATA_W-1:0] d, input bit odd);
`ifdef UART_TX_PARITY_EN
    return {1'b1, (^d) ^ odd, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // pos: 0 idle, 1..FT inside the frame, FT+1 the DONE cycle.
  int                pos = 0;
  logic [DATA_W-1:0] m_data = '0;

  function automatic bit in_frame();
    return (pos >= 1) && (pos <= FT);
  endfunction

  function automatic bit exp_tx(input bit odd);
    logic [FW-1:0] f;
    if (!in_frame()) return 1'b1;
    f = frame_of(m_data, odd);
    return f[(pos - 1) / C];
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET)                      pos = 0;
    else if (start && !in_frame()) begin pos = 1; m_data = data_in; end
    else if (in_frame())             pos = pos + 1;
    else                             pos = 0;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("tx0",   32'(b0.TX),   32'(exp_tx(1'b0)));
      check("tx1",   32'(b1.TX),   32'(exp_tx(1'b1)));
      check("busy0", 32'(b0.BUSY), 32'(in_frame()));
      check("busy1", 32'(b1.BUSY), 32'(in_frame()));
      check("done0", 32'(b0.DONE), 32'(pos == FT + 1));
      check("done1", 32'(b1.DONE), 32'(pos == FT + 1));
    end
  end

  // Caller has START=1 and DATA_IN set before the accepting edge; loop covers cycles 1..FT+1.
  task automatic frame_chk(input string nm, input logic [FW-1:0] e0, input logic [FW-1:0] e1,
                           input bit hold, input int poke, input logic [DATA_W-1:0] pdata);
    logic [FW-1:0] g0 = '0;
    logic [FW-1:0] g1 = '0;
    for (int cyc = 1; cyc <= FT + 1; cyc++) begin
      @(negedge CLK);
      if (cyc == 1 && !hold) start = 1'b0;
      if (cyc == 1 && !hold && poke == 0) data_in = ~data_in;
      if (poke != 0 && cyc == poke) begin start = 1'b1; data_in = pdata; end
      else if (poke != 0 && cyc == poke + 1 && !hold) start = 1'b0;
      if (cyc == 1) check({nm, "_startbit"}, 32'(b0.TX), 32'd0);
      if (cyc >= 2 && (cyc - 2) % C == 0 && (cyc - 2) / C < FW) begin
        g0[(cyc - 2) / C] = b0.TX;
        g1[(cyc - 2) / C] = b1.TX;
      end
      if (cyc == FT) check({nm, "_busy_last"}, 32'(b0.BUSY), 32'd1);
      if (cyc == FT + 1) begin
        check({nm, "_done0"}, 32'(b0.DONE), 32'd1);
        check({nm, "_done1"}, 32'(b1.DONE), 32'd1);
        check({nm, "_idle_tx"}, 32'(b0.TX), 32'd1);
        check({nm, "_busy_done"}, 32'(b0.BUSY), 32'd0);
      end
    end
    check({nm, "_bits0"}, 32'(g0), 32'(e0));
    check({nm, "_bits1"}, 32'(g1), 32'(e1));
  endtask

`ifdef UART_TX_PARITY_EN
  localparam logic [FW-1:0] E_A5_0 = {1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [FW-1:0] E_A5_1 = {1'b1, 1'b1, 8'hA5, 1'b0};
  localparam logic [FW-1:0] E_FF_0 = {1'b1, 1'b0, 8'hFF, 1'b0};
  localparam logic [FW-1:0] E_FF_1 = {1'b1, 1'b1, 8'hFF, 1'b0};
  localparam logic [FW-1:0] E_3C_0 = {1'b1, 1'b0, 8'h3C, 1'b0};
  localparam logic [FW-1:0] E_3C_1 = {1'b1, 1'b1, 8'h3C, 1'b0};
  localparam logic [FW-1:0] E_01_0 = {1'b1, 1'b1, 8'h01, 1'b0};
  localparam logic [FW-1:0] E_01_1 = {1'b1, 1'b0, 8'h01, 1'b0};
  localparam logic [FW-1:0] E_80_0 = {1'b1, 1'b1, 8'h80, 1'b0};
  localparam logic [FW-1:0] E_80_1 = {1'b1, 1'b0, 8'h80, 1'b0};
  localparam logic [FW-1:0] E_55_0 = {1'b1, 1'b0, 8'h55, 1'b0};
  localparam logic [FW-1:0] E_55_1 = {1'b1, 1'b1, 8'h55, 1'b0};
`else
  localparam logic [FW-1:0] E_A5_0 = {1'b1, 8'hA5, 1'b0};
  localparam logic [FW-1:0] E_A5_1 = E_A5_0;
  localparam logic [FW-1:0] E_FF_0 = {1'b1, 8'hFF, 1'b0};
  localparam logic [FW-1:0] E_FF_1 = E_FF_0;
  localparam logic [FW-1:0] E_3C_0 = {1'b1, 8'h3C, 1'b0};
  localparam logic [FW-1:0] E_3C_1 = E_3C_0;
  localparam logic [FW-1:0] E_01_0 = {1'b1, 8'h01, 1'b0};
  localparam logic [FW-1:0] E_01_1 = E_01_0;
  localparam logic [FW-1:0] E_80_0 = {1'b1, 8'h80, 1'b0};
  localparam logic [FW-1:0] E_80_1 = E_80_0;
  localparam logic [FW-1:0] E_55_0 = {1'b1, 8'h55, 1'b0};
  localparam logic [FW-1:0] E_55_1 = E_55_0;
`endif

  initial begin
    #2 RESET = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_tx",   32'(b0.TX),   32'd1);
    check("rst_busy", 32'(b0.BUSY), 32'd0);
    check("rst_done", 32'(b0.DONE), 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    data_in = 8'hA5; start = 1'b1;
    frame_chk("a5", E_A5_0, E_A5_1, 1'b0, 0, '0);
    repeat (3) @(negedge CLK);
    check("a5_after_tx", 32'(b0.TX), 32'd1);

    data_in = 8'hFF; start = 1'b1;
    frame_chk("ff", E_FF_0, E_FF_1, 1'b0, 0, '0);
    repeat (2) @(negedge CLK);

    data_in = 8'h3C; start = 1'b1;
    frame_chk("busy_ign", E_3C_0, E_3C_1, 1'b0, 10, 8'h00);
    repeat (4) @(negedge CLK);
    check("busy_ign_no2nd", 32'(b0.BUSY), 32'd0);

    data_in = 8'h01; start = 1'b1;
    frame_chk("b2b_a", E_01_0, E_01_1, 1'b1, 1, 8'h80);
    frame_chk("b2b_b", E_80_0, E_80_1, 1'b0, 0, '0);
    repeat (2) @(negedge CLK);

    data_in = 8'h55; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (19) @(negedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    check("midrst_tx",   32'(b0.TX),   32'd1);
    check("midrst_busy", 32'(b0.BUSY), 32'd0);
    check("midrst_done", 32'(b0.DONE), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    data_in = 8'h55; start = 1'b1;
    frame_chk("post_rst", E_55_0, E_55_1, 1'b0, 0, '0);

    repeat (1500) begin
      @(negedge CLK);
      start   = ($urandom_range(0, 11) == 0);
      data_in = DATA_W'($urandom);
    end
    @(negedge CLK); start = 1'b0;
    repeat (FT + 4) @(negedge CLK);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
